// File: rtl/reset_requester_if.sv
// CSR bus bundle shared by the system-control peripherals.
// The bus master drives address, write strobe and write data; the peripheral returns registered read data.
interface reset_requester_if;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;

    modport master (output csr_a, csr_we, csr_di, input csr_do);
    modport slave  (input csr_a, csr_we, csr_di, output csr_do);
endinterface

// File: rtl/reset_requester.sv
// Reset request unit: merges keyed soft reset, lockable watchdog and debounced push-button
// into the trigger_reset pulse, and keeps a cause register that survives system reset.
module reset_requester #(
    parameter logic [3:0]  csr_addr    = 4'h0,
    parameter logic [31:0] SOFT_KEY    = 32'h5EB00700,
    parameter logic [15:0] WDT_KEY     = 16'hC0DE,
    parameter logic [31:0] WDT_DEFAULT = 32'd80_000_000,
    parameter logic [19:0] DEBOUNCE    = 20'd800_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    reset_requester_if.slave csr,
    input  logic             btn_n,
    output logic             trigger_reset
);
    localparam logic [2:0] REG_SOFT   = 3'd0;
    localparam logic [2:0] REG_RELOAD = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_COUNT  = 3'd3;
    localparam logic [2:0] REG_CAUSE  = 3'd4;

    logic        sel;
    logic        wr;
    logic [2:0]  reg_sel;
    logic        ctrl_wr_ok;
    logic [31:0] rd_data;

    logic        wdt_en;
    logic [31:0] wdt_count;
    logic [31:0] wdt_reload;

    logic [1:0]  btn_sync;
    logic [1:0]  sync_vld;
    logic        btn_s;
    logic [19:0] btn_cnt;
    logic        armed;

    // Not touched by sys_rst: holds power-on until the first request or clear.
    logic [3:0]  cause = 4'b0001;

    logic        soft_req;
    logic        wdt_req;
    logic        btn_req;
    logic        any_req;
    logic        unused_addr_bits;

    assign sel        = (csr.csr_a[13:10] == csr_addr);
    assign wr         = sel && csr.csr_we;
    assign reg_sel    = csr.csr_a[2:0];
    assign ctrl_wr_ok = wr && (reg_sel == REG_CTRL) && (csr.csr_di[31:16] == WDT_KEY);
    assign unused_addr_bits = ^csr.csr_a[9:3];

    assign btn_s    = btn_sync[1];
    assign soft_req = wr && (reg_sel == REG_SOFT) && (csr.csr_di == SOFT_KEY);
    assign wdt_req  = wdt_en && (wdt_count == '0);
    assign btn_req  = armed && (btn_cnt == DEBOUNCE);
    assign any_req  = soft_req || wdt_req || btn_req;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_RELOAD: rd_data = wdt_reload;
            REG_CTRL:   rd_data = {31'd0, wdt_en};
            REG_COUNT:  rd_data = wdt_count;
            REG_CAUSE:  rd_data = {28'd0, cause};
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            trigger_reset <= 1'b0;
            csr.csr_do    <= '0;
            wdt_en        <= 1'b0;
            wdt_count     <= '0;
            wdt_reload    <= WDT_DEFAULT;
            btn_sync      <= 2'b11;
            sync_vld      <= 2'b00;
            btn_cnt       <= '0;
            armed         <= 1'b0;
        end else begin
            trigger_reset <= any_req;
            csr.csr_do    <= sel ? rd_data : '0;

            if (wr && (reg_sel == REG_RELOAD))
                wdt_reload <= csr.csr_di;

            // Enable is sticky; a kick only reloads once the dog is running.
            if (ctrl_wr_ok && csr.csr_di[0]) begin
                wdt_en    <= 1'b1;
                wdt_count <= wdt_reload;
            end else if (ctrl_wr_ok && csr.csr_di[1] && wdt_en) begin
                wdt_count <= wdt_reload;
            end else if (wdt_en && (wdt_count != '0)) begin
                wdt_count <= wdt_count - 32'd1;
            end

            btn_sync <= {btn_sync[0], btn_n};
            sync_vld <= {sync_vld[0], 1'b1};
            btn_cnt  <= btn_s ? '0 : btn_cnt + 20'd1;

            // Arm only on a real released sample, not on the synchronizer's reset fill,
            // so a button held through reset cannot fire until released.
            if (btn_req)
                armed <= 1'b0;
            else if (btn_s && sync_vld[1])
                armed <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            if (any_req)
                cause <= {btn_req, wdt_req, soft_req, 1'b0};
            else if (wr && (reg_sel == REG_CAUSE))
                cause <= '0;
        end
    end
endmodule

// File: tb/tb_reset_requester.sv
// Bench for reset_requester: directed steps then random traffic, every cycle compared
// against a deadline/run-length reference model of the request sources.
module tb_reset_requester;
    localparam logic [31:0] SOFT_KEY = 32'h5EB00700;
    localparam logic [31:0] WDT_DEF  = 32'd80_000_000;
    localparam int          DEB      = 16;
    localparam int          LOGN     = 4096;

    logic sys_clk;
    logic sys_rst;
    logic btn_n;
    logic trigger_reset;

    reset_requester_if bus ();

    reset_requester #(.DEBOUNCE(20'd16)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .csr           (bus),
        .btn_n         (btn_n),
        .trigger_reset (trigger_reset)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pulses = 0;
    int last_trig = -1000;

    // Reference model: watchdog as an absolute deadline, button as run lengths of synced samples.
    logic        m_en = 1'b0;
    logic [31:0] m_reload = WDT_DEF;
    longint      m_fire_from = 0;
    logic [3:0]  m_cause = 4'b0001;
    int          m_run_len = 0;
    logic        m_run_ok = 1'b0;
    int          m_last_rst = 0;
    bit          btn_log [LOGN];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic        sel, wr, soft_q, wdt_q, btn_q, syn, gen, exp_trig;
        logic [2:0]  r;
        logic [31:0] di, cnt_now, rd, exp_do;
        sel = (bus.csr_a[13:10] == 4'h0);
        wr  = sel && bus.csr_we;
        r   = bus.csr_a[2:0];
        di  = bus.csr_di;
        cnt_now = '0;
        if (m_en && (longint'(cyc) < m_fire_from - 1))
            cnt_now = 32'(m_fire_from - 1 - longint'(cyc));
        soft_q = !sys_rst && wr && (r == 3'd0) && (di == SOFT_KEY);
        wdt_q  = !sys_rst && m_en && (longint'(cyc) >= m_fire_from - 1);
        btn_q  = !sys_rst && m_run_ok && (m_run_len == DEB);
        case (r)
            3'd1:    rd = m_reload;
            3'd2:    rd = {31'd0, m_en};
            3'd3:    rd = cnt_now;
            3'd4:    rd = {28'd0, m_cause};
            default: rd = '0;
        endcase
        exp_do   = (sys_rst || !sel) ? 32'd0 : rd;
        exp_trig = soft_q || wdt_q || btn_q;
        btn_log[cyc % LOGN] = btn_n;
        gen = (cyc >= 2) && (cyc - 2 > m_last_rst);
        syn = gen ? btn_log[(cyc - 2) % LOGN] : 1'b1;

        @(posedge sys_clk);
        #1;
        tests++;
        assert (trigger_reset === exp_trig) else begin
            fails++;
            $error("FAIL trigger cyc=%0d got %b expected %b", cyc + 1, trigger_reset, exp_trig);
        end
        tests++;
        assert (bus.csr_do === exp_do) else begin
            fails++;
            $error("FAIL csr_do cyc=%0d got %0h expected %0h", cyc + 1, bus.csr_do, exp_do);
        end
        if (trigger_reset === 1'b1) begin
            pulses++;
            last_trig = cyc + 1;
        end

        if (sys_rst) begin
            m_en       = 1'b0;
            m_reload   = WDT_DEF;
            m_run_len  = 0;
            m_run_ok   = 1'b0;
            m_last_rst = cyc;
        end else begin
            if (soft_q || wdt_q || btn_q)
                m_cause = {btn_q, wdt_q, soft_q, 1'b0};
            else if (wr && (r == 3'd4))
                m_cause = 4'b0000;
            if (wr && (r == 3'd2) && (di[31:16] == 16'hC0DE)) begin
                if (di[0]) begin
                    m_en        = 1'b1;
                    m_fire_from = longint'(cyc) + 2 + longint'(m_reload);
                end else if (di[1] && m_en) begin
                    m_fire_from = longint'(cyc) + 2 + longint'(m_reload);
                end
            end
            if (wr && (r == 3'd1))
                m_reload = di;
            if (btn_q)
                m_run_ok = 1'b0;
            else if (syn && gen)
                m_run_ok = 1'b1;
            m_run_len = syn ? 0 : m_run_len + 1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr_csr(input logic [2:0] r, input logic [31:0] d);
        bus.csr_a  = {4'h0, 7'h00, r};
        bus.csr_we = 1'b1;
        bus.csr_di = d;
        step();
        bus.csr_we = 1'b0;
        bus.csr_di = '0;
    endtask

    task automatic rd_csr(input logic [2:0] r, output logic [31:0] d);
        bus.csr_a  = {4'h0, 7'h00, r};
        bus.csr_we = 1'b0;
        step();
        d = bus.csr_do;
    endtask

    task automatic rst_pulse(input int n);
        sys_rst = 1'b1;
        idle(n);
        sys_rst = 1'b0;
    endtask

    task automatic wait_pulse(input int budget);
        last_trig = -1000;
        pulses = 0;
        for (int i = 0; i < budget && pulses == 0; i++) step();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int wcyc;
        sys_rst = 1'b1;
        btn_n = 1'b1;
        bus.csr_a = '0;
        bus.csr_we = 1'b0;
        bus.csr_di = '0;
        idle(3);
        sys_rst = 1'b0;
        check("rst_trigger", {31'd0, trigger_reset}, 32'd0);

        rd_csr(3'd0, d); check("rst_soft", d, 32'd0);
        rd_csr(3'd1, d); check("rst_reload", d, WDT_DEF);
        rd_csr(3'd2, d); check("rst_ctrl", d, 32'd0);
        rd_csr(3'd3, d); check("rst_count", d, 32'd0);
        rd_csr(3'd4, d); check("rst_cause_por", d, 32'd1);
        for (int r = 5; r < 8; r++) begin
            rd_csr(3'(r), d);
            check("reg_5_7", d, 32'd0);
        end
        bus.csr_a = {4'h5, 7'h00, 3'd1};
        step();
        check("unselected_bank", bus.csr_do, 32'd0);

        pulses = 0;
        wr_csr(3'd0, 32'h5EB00701);
        idle(3);
        check("soft_badkey", pulses, 0);
        wr_csr(3'd0, SOFT_KEY);
        idle(3);
        check("soft_single_pulse", pulses, 1);
        rd_csr(3'd4, d); check("soft_cause", d, 32'h2);

        wr_csr(3'd1, 32'd10);
        pulses = 0;
        wr_csr(3'd2, 32'h12340001);
        idle(20);
        check("wdt_badkey_pulse", pulses, 0);
        rd_csr(3'd2, d); check("wdt_badkey_ctrl", d, 32'd0);

        wcyc = cyc;
        wr_csr(3'd2, 32'hC0DE0001);
        wait_pulse(30);
        check("wdt_latency_12", last_trig - wcyc, 12);
        rd_csr(3'd4, d); check("wdt_cause", d, 32'h4);
        rst_pulse(1);

        wr_csr(3'd1, 32'd0);
        wcyc = cyc;
        wr_csr(3'd2, 32'hC0DE0001);
        wait_pulse(10);
        check("wdt_reload0_latency", last_trig - wcyc, 2);
        rst_pulse(1);

        wr_csr(3'd1, 32'd10);
        wr_csr(3'd2, 32'hC0DE0001);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            idle(4);
            wr_csr(3'd2, 32'hC0DE0002);
        end
        check("wdt_kick_no_pulse", pulses, 0);
        wr_csr(3'd2, 32'hC0DE0000);
        rd_csr(3'd2, d); check("wdt_enable_sticky", d, 32'd1);
        rst_pulse(1);

        idle(4);
        pulses = 0;
        btn_n = 1'b0; idle(15);
        btn_n = 1'b1; idle(25);
        check("btn_short_press", pulses, 0);
        btn_n = 1'b0; idle(40);
        btn_n = 1'b1; idle(5);
        check("btn_long_press", pulses, 1);
        rd_csr(3'd4, d); check("btn_cause", d, 32'h8);

        btn_n = 1'b0; idle(3);
        rst_pulse(2);
        pulses = 0;
        idle(40);
        check("btn_held_through_reset", pulses, 0);
        btn_n = 1'b1; idle(5);
        btn_n = 1'b0; idle(40);
        btn_n = 1'b1; idle(3);
        check("btn_repress", pulses, 1);

        rst_pulse(1);
        wr_csr(3'd1, 32'd5);
        wr_csr(3'd2, 32'hC0DE0001);
        idle(5);
        wr_csr(3'd0, SOFT_KEY);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        rd_csr(3'd4, d); check("simul_cause_kept", d, 32'h6);
        wr_csr(3'd4, 32'hFFFF_FFFF);
        rd_csr(3'd4, d); check("cause_cleared", d, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            sys_rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 23) == 0) btn_n = ~btn_n;
            bus.csr_we = ($urandom_range(0, 3) == 0);
            bus.csr_a = {($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                         7'($urandom), 3'($urandom_range(0, 7))};
            case ($urandom_range(0, 4))
                0:       bus.csr_di = SOFT_KEY;
                1:       bus.csr_di = {16'hC0DE, 16'($urandom_range(0, 3))};
                2:       bus.csr_di = $urandom_range(0, 40);
                3:       bus.csr_di = $urandom;
                default: bus.csr_di = {16'($urandom), 16'($urandom_range(0, 3))};
            endcase
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reset_requester.md
# reset_requester

CSR-mapped reset request unit that produces the one-cycle `trigger_reset` pulse consumed by the system reset generator. It merges three sources into that pulse: a keyed software reset write, a lockable watchdog timer, and a debounced front-panel push-button. It also keeps a reset-cause register that survives the resulting system reset. It sits on the CSR bus beside the other system-control peripherals.

## Interface
- `csr_addr`, default 4'h0: CSR bank select, compared with `csr_a[13:10]`.
- `SOFT_KEY`, default 32'h5EB00700: value that must be written to SOFT to request a reset.
- `WDT_KEY`, default 16'hC0DE: required in `csr_di[31:16]` for any WDT_CTRL write to take effect.
- `WDT_DEFAULT`, default 32'd80_000_000: reset value of WDT_RELOAD.
- `DEBOUNCE`, default 20'd800_000: number of stable-pressed cycles before the button fires.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: synchronous active-high reset.
- `csr_a` in 14: CSR address. `[13:10]` is the bank; `[2:0]` is the register.
- `csr_we` in 1: CSR write strobe.
- `csr_di` in 32: CSR write data.
- `csr_do` out 32: CSR read data, registered.
- `btn_n` in 1: asynchronous push-button, active-low.
- `trigger_reset` out 1: reset request pulse to the reset generator.

## Operation
- Bank selected when `csr_a[13:10] == csr_addr`.
  - Reads: `csr_do` is the register value. When not selected, `csr_do` is 0.
  - Writes: take effect only when selected and `csr_we` is high.
- Registers (`csr_a[2:0]`):
  - 0 SOFT: writing exactly `SOFT_KEY` raises a soft request. Any other value is ignored. Reads 0.
  - 1 WDT_RELOAD: 32-bit RW. Reset value `WDT_DEFAULT`.
  - 2 WDT_CTRL (write ignored unless `csr_di[31:16] == WDT_KEY`):
    - bit0=1 enables the watchdog and loads count with the current RELOAD value.
    - bit1=1 kicks, loading count with RELOAD, and is honoured only while enabled.
    - Enable is sticky: writing bit0=0 never disables; only `sys_rst` clears it.
    - Read: bit0 = enabled, other bits 0.
  - 3 WDT_COUNT: reads the live count. Writes ignored.
  - 4 CAUSE: bit0 power-on, bit1 soft, bit2 watchdog, bit3 button. Any write clears it to 0.
  - 5–7: read 0, writes ignored.
- Watchdog:
  - While enabled, count decrements by 1 per cycle, stopping at 0.
  - Enabled with count == 0 raises a watchdog request every cycle.
  - RELOAD writes do not affect a running count until the next kick.
- Button:
  - `btn_n` passes through a 2-flop synchronizer.
  - A 20-bit counter increments while the synced input is low and clears whenever it is high.
  - An `armed` flag is cleared by `sys_rst` and set when the synced input is seen high.
  - When the counter reaches `DEBOUNCE` while armed, a button request is raised for one cycle and `armed` clears.
  - A button held through reset therefore never re-fires until it has been released.
- Trigger and cause:
  - If any request is raised in cycle N, `trigger_reset` is 1 in cycle N+1.
  - In that same edge, CAUSE is loaded with exactly the set of sources active in cycle N; all simultaneous sources are recorded.
- CAUSE is not cleared by `sys_rst`; its initial (configuration) value is 4'b0001.
  - Priority when a CSR clear of CAUSE and a trigger land in the same cycle: the trigger load wins.
- All other state is cleared by `sys_rst`.

## Timing
- Reset values: `trigger_reset`=0, `csr_do`=0, enable=0, count=0, RELOAD=`WDT_DEFAULT`, debounce counter=0, armed=0, synchronizer flops=1.
- While `sys_rst` is high, `trigger_reset` is forced 0 and all requests are ignored.
- Soft path: write in cycle N gives `trigger_reset` high in cycle N+1, for exactly one cycle.
- Watchdog: enable at cycle N gives count=RELOAD at N+1, reaching 0 at N+1+RELOAD. `trigger_reset` is high one cycle after count first reads 0.
- Kick and count==0 in the same cycle: the request still fires, and the kick reloads.
- RELOAD = 0 with enable: triggers 2 cycles after the enable write.
- CSR read latency is 1 cycle.
- `trigger_reset` repeats each cycle while a request persists (watchdog at 0). The downstream generator tolerates repeats.

## Test plan
- Soft reset: write 0x5EB00700 to reg 0, then check a single-cycle `trigger_reset` and CAUSE=4'b0010. Writing 0x5EB00701 produces no pulse.
- Watchdog:
  - RELOAD=10, enable with 0xC0DE0001: `trigger_reset` exactly 12 cycles after the write; CAUSE=4'b0100.
  - The same write with key 0x1234 does nothing.
- Kick and lock:
  - Kicking every 5 cycles with RELOAD=10 never triggers.
  - Writing 0xC0DE0000 leaves WDT_CTRL reading 1.
- Button:
  - DEBOUNCE=16 with `btn_n` low for 15 cycles then high: no pulse.
  - Low for 40 cycles: exactly one pulse, and CAUSE=4'b1000.
  - Holding low through `sys_rst`: no pulse until released and pressed again.
- Simultaneous sources and CAUSE retention:
  - A soft write in the same cycle as a watchdog expiry gives CAUSE=4'b0110.
  - After a `sys_rst` pulse, CAUSE is still 4'b0110; a write to reg 4 then reads 0.
- CSR and reset values: check every reset value, including RELOAD=`WDT_DEFAULT`. Read to an unselected bank gives `csr_do`=0. Registers 5–7 read 0.
